// File: rtl/eth_frame_pkg.sv
// ============================================================================
// Module : eth_frame_pkg
// Brief  : Shared Ethernet frame state codes, constants and CRC-32 step.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_frame_pkg;

    typedef enum logic [2:0] {
        NO_FRAME  = 3'b000,
        PREAMBLE  = 3'b001,
        DELIMETER = 3'b010,
        DA        = 3'b011,
        SA        = 3'b100,
        LENGTH    = 3'b101,
        DATA      = 3'b110,
        FCS       = 3'b111
    } frame_state_e;

    localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] c_CRC_PRESET    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CRC_POLY_REFL = 32'hEDB8_8320;

    // Reflected CRC-32 over one byte, LSB of the byte first.
    function automatic logic [31:0] eth_crc32_8d(input logic [7:0] data,
                                                 input logic [31:0] crc);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ c_CRC_POLY_REFL;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_crc32_acc.sv
// ============================================================================
// Module : tx_crc32_acc
// Brief  : Byte-wide CRC-32 accumulator with synchronous preset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_crc32_acc
    import eth_frame_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        preset_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= c_CRC_PRESET;
        end else if (preset_i) begin
            crc_q <= c_CRC_PRESET;
        end else if (en_i) begin
            crc_q <= eth_crc32_8d(data_i, crc_q);
        end
    end

    assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/frame_transmitter.sv
// ============================================================================
// Module : frame_transmitter
// Brief  : GMII-style Ethernet frame transmitter with padding, FCS and IFG.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_transmitter
    import eth_frame_pkg::*;
#(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic [47:0] ida,
    input  logic [47:0] isa,
    input  logic [15:0] ilen,
    input  logic [7:0]  idata,
    input  logic        ivalid,
    input  logic        ilast,
    output logic        o_ready,
    output logic [7:0]  otx_data,
    output logic        otx_en,
    output logic        otx_er,
    output logic [2:0]  o_state,
    output logic        o_busy,
    output logic        o_error
);

    // The state names the byte being issued into the output register this
    // cycle, so the wire lags the reported state by one cycle.
    typedef enum logic [3:0] {
        S_IDLE = {1'b0, NO_FRAME},
        S_PRE  = {1'b0, PREAMBLE},
        S_SFD  = {1'b0, DELIMETER},
        S_DA   = {1'b0, DA},
        S_SA   = {1'b0, SA},
        S_LEN  = {1'b0, LENGTH},
        S_DATA = {1'b0, DATA},
        S_FCS  = {1'b0, FCS},
        S_IFG  = 4'b1000
    } tx_state_e;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        pad_q, pad_d;
    logic [47:0] da_q, da_d, sa_q, sa_d, da_sh, sa_sh;
    logic [15:0] len_q, len_d, len_sh;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d, err_q, err_d;
    logic        crc_preset, crc_en;
    logic [31:0] crc_val, fcs_sh;

    tx_crc32_acc u_crc (
        .clk_i    (iclk),
        .rst_i    (irst),
        .preset_i (crc_preset),
        .en_i     (crc_en),
        .data_i   (tx_data_d),
        .crc_o    (crc_val)
    );

    assign o_ready  = (state_q == S_DATA) && !pad_q && (cnt_q != 16'(MAX_PAYLOAD));
    assign o_busy   = (state_q != S_IDLE);
    assign o_state  = state_q[2:0];
    assign otx_data = tx_data_q;
    assign otx_en   = tx_en_q;
    assign otx_er   = tx_er_q;
    assign o_error  = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pad_d      = pad_q;
        da_d       = da_q;
        sa_d       = sa_q;
        len_d      = len_q;
        tx_data_d  = 8'h00;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        err_d      = 1'b0;
        crc_preset = 1'b0;
        crc_en     = 1'b0;
        cnt_inc    = cnt_q + 16'd1;
        da_sh      = da_q << {cnt_q[2:0], 3'b000};
        sa_sh      = sa_q << {cnt_q[2:0], 3'b000};
        len_sh     = len_q << {cnt_q[0], 3'b000};
        fcs_sh     = (~crc_val) >> {cnt_q[1:0], 3'b000};

        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    da_d      = ida;
                    sa_d      = isa;
                    len_d     = ilen;
                    tx_data_d = c_PREAMBLE_BYTE;
                    tx_en_d   = 1'b1;
                    state_d   = S_PRE;
                    cnt_d     = 16'd1;
                end
            end
            S_PRE: begin
                tx_data_d = c_PREAMBLE_BYTE;
                tx_en_d   = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_q == 16'd6) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end
            end
            S_SFD: begin
                tx_data_d  = c_SFD_BYTE;
                tx_en_d    = 1'b1;
                crc_preset = 1'b1;
                state_d    = S_DA;
                cnt_d      = '0;
            end
            S_DA, S_SA: begin
                tx_data_d = (state_q == S_DA) ? da_sh[47:40] : sa_sh[47:40];
                tx_en_d   = 1'b1;
                crc_en    = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_q == 16'd5) begin
                    state_d = (state_q == S_DA) ? S_SA : S_LEN;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                tx_data_d = len_sh[15:8];
                tx_en_d   = 1'b1;
                crc_en    = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_q == 16'd1) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    pad_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (pad_q) begin
                    tx_en_d = 1'b1;
                    crc_en  = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= 16'(MIN_PAYLOAD)) begin
                        state_d = S_FCS;
                        cnt_d   = '0;
                        pad_d   = 1'b0;
                    end
                end else if (ivalid && (cnt_q != 16'(MAX_PAYLOAD))) begin
                    tx_data_d = idata;
                    tx_en_d   = 1'b1;
                    crc_en    = 1'b1;
                    cnt_d     = cnt_inc;
                    if (ilast) begin
                        if (cnt_inc >= 16'(MIN_PAYLOAD)) begin
                            state_d = S_FCS;
                            cnt_d   = '0;
                        end else begin
                            pad_d = 1'b1;
                        end
                    end
                end else begin
                    // Underrun, or payload limit reached without ilast.
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_FCS: begin
                tx_data_d = fcs_sh[7:0];
                tx_en_d   = 1'b1;
                cnt_d     = cnt_inc;
                if (cnt_q == 16'd3) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
            S_IFG: begin
                // One extra cycle covers the final byte still on the wire.
                cnt_d = cnt_inc;
                if (cnt_q == 16'(IFG_CYCLES)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pad_q     <= 1'b0;
            da_q      <= '0;
            sa_q      <= '0;
            len_q     <= '0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pad_q     <= pad_d;
            da_q      <= da_d;
            sa_q      <= sa_d;
            len_q     <= len_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            err_q     <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_transmitter.sv
// ============================================================================
// Module : tb_frame_transmitter
// Brief  : Directed self-checking bench for frame_transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_transmitter;

    logic        iclk = 1'b0;
    logic        irst, istart, ivalid, ilast;
    logic [47:0] ida, isa;
    logic [15:0] ilen;
    logic [7:0]  idata;
    logic        o_ready, otx_en, otx_er, o_busy, o_error;
    logic [7:0]  otx_data;
    logic [2:0]  o_state;

    int total = 0;
    int bad   = 0;

    frame_transmitter dut (
        .iclk     (iclk),
        .irst     (irst),
        .istart   (istart),
        .ida      (ida),
        .isa      (isa),
        .ilen     (ilen),
        .idata    (idata),
        .ivalid   (ivalid),
        .ilast    (ilast),
        .o_ready  (o_ready),
        .otx_data (otx_data),
        .otx_en   (otx_en),
        .otx_er   (otx_er),
        .o_state  (o_state),
        .o_busy   (o_busy),
        .o_error  (o_error)
    );

    always #5 iclk = ~iclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wire monitor, sampled on the inactive edge.
    logic [7:0] cap[$];
    int en_n, er_n, rdy_n, err_n, ifg_n, idle_bad;

    always @(negedge iclk) begin
        if (otx_en) begin
            cap.push_back(otx_data);
            en_n++;
        end else if (otx_data != 8'h00) begin
            idle_bad++;
        end
        if (otx_er)             er_n++;
        if (o_ready)            rdy_n++;
        if (o_error)            err_n++;
        if (o_busy && !otx_en)  ifg_n++;
    end

    task automatic clear_mon();
        cap.delete();
        en_n = 0; er_n = 0; rdy_n = 0; err_n = 0; ifg_n = 0; idle_bad = 0;
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++)
            c = (c[0] ^ b[k]) ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = v[31-k];
        return r;
    endfunction

    // Called at a falling edge with o_busy low; returns at the first falling
    // edge where o_busy is low again.
    task automatic run_frame(input int n, input bit with_last, input int drop_at,
                             input bit poke, input logic [7:0] seed, input string tag);
        logic [47:0] da, sa;
        logic [15:0] ln;
        logic [7:0]  ex[$];
        logic [31:0] r;
        int nacc, exp_en, exp_rdy, mis, i, budget;
        bit abort, poked, acc;

        abort   = !with_last || (drop_at >= 0);
        nacc    = (drop_at >= 0) ? drop_at : (with_last ? n : 1500);
        exp_en  = abort ? (22 + nacc + 1) : (22 + ((n < 46) ? 46 : n) + 4);
        exp_rdy = (drop_at >= 0) ? nacc + 1 : nacc;
        da = 48'h0A1B_2C3D_4E5F ^ {6{seed}};
        sa = 48'h6070_8090_A0B0 ^ {6{seed}};
        ln = 16'(n);

        for (int k = 0; k < 7; k++) ex.push_back(8'h55);
        ex.push_back(8'hD5);
        for (int k = 5; k >= 0; k--) ex.push_back(da[8*k +: 8]);
        for (int k = 5; k >= 0; k--) ex.push_back(sa[8*k +: 8]);
        ex.push_back(ln[15:8]);
        ex.push_back(ln[7:0]);
        for (int k = 0; k < nacc; k++) ex.push_back(seed + 8'(k * 37));
        if (!abort) for (int k = nacc; k < 46; k++) ex.push_back(8'h00);

        clear_mon();
        ida = da; isa = sa; ilen = ln; istart = 1'b1;
        @(posedge iclk); #1;
        istart = 1'b0; ida = ~da; isa = ~sa; ilen = ~ln;

        i = 0; poked = 0; budget = 0;
        while (budget < 4000) begin
            ivalid = (i < n) && (i != drop_at);
            idata  = seed + 8'(i * 37);
            ilast  = with_last && (i == n - 1);
            @(negedge iclk);
            if (budget == 0) begin
                check_val({tag, " sop_en"}, {31'b0, otx_en}, 32'd1);
                check_val({tag, " sop_data"}, {24'b0, otx_data}, 32'h55);
            end
            if (!o_busy) break;
            acc = o_ready && ivalid;
            if (poke && !poked && en_n > 0 && !otx_en) begin
                istart = 1'b1;
                poked  = 1;
            end
            @(posedge iclk); #1;
            istart = 1'b0;
            if (acc) i++;
            budget++;
        end
        ivalid = 1'b0; ilast = 1'b0;
        if (budget >= 4000) check_val({tag, " timeout"}, 32'd1, 32'd0);

        check_val({tag, " en_cycles"}, en_n, exp_en);
        check_val({tag, " er_cycles"}, er_n, abort ? 1 : 0);
        check_val({tag, " err_pulses"}, err_n, abort ? 1 : 0);
        check_val({tag, " ready_cycles"}, rdy_n, exp_rdy);
        check_val({tag, " ifg_cycles"}, ifg_n, 12);
        check_val({tag, " idle_data"}, idle_bad, 0);
        mis = 0;
        for (int k = 0; k < ex.size(); k++)
            if (k >= cap.size() || cap[k] !== ex[k]) mis++;
        check_val({tag, " byte_mismatches"}, mis, 0);
        if (!abort) begin
            r = 32'hFFFF_FFFF;
            for (int k = 8; k < cap.size(); k++) r = crc_step(r, cap[k]);
            check_val({tag, " crc_residue"}, bitrev32(r), 32'hC704_DD7B);
        end
    endtask

    initial begin
        irst = 1'b1; istart = 1'b0; ivalid = 1'b0; ilast = 1'b0;
        idata = 8'h00; ida = '0; isa = '0; ilen = '0;
        clear_mon();
        repeat (2) @(negedge iclk);
        check_val("rst otx_en", {31'b0, otx_en}, 0);
        check_val("rst otx_er", {31'b0, otx_er}, 0);
        check_val("rst otx_data", {24'b0, otx_data}, 0);
        check_val("rst o_ready", {31'b0, o_ready}, 0);
        check_val("rst o_busy", {31'b0, o_busy}, 0);
        check_val("rst o_error", {31'b0, o_error}, 0);
        check_val("rst o_state", {29'b0, o_state}, 0);
        irst = 1'b0;
        @(negedge iclk);

        run_frame(46,   1, -1, 0, 8'h10, "p46");
        run_frame(1,    1, -1, 1, 8'hAB, "p1");
        run_frame(1500, 1, -1, 0, 8'h33, "p1500");
        run_frame(1501, 0, -1, 0, 8'h44, "ovf");
        run_frame(20,   1,  9, 0, 8'h5A, "urun");

        // Reset while the source address is being sent.
        ida = 48'h1111_2222_3333; isa = 48'h4444_5555_6666; ilen = 16'd50;
        istart = 1'b1;
        @(posedge iclk); #1;
        istart = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge iclk);
            if (o_state == 3'b100) break;
        end
        check_val("rst_sa reached", {29'b0, o_state}, 32'd4);
        #2 irst = 1'b1;
        #1;
        check_val("rst_sa otx_en", {31'b0, otx_en}, 0);
        check_val("rst_sa otx_er", {31'b0, otx_er}, 0);
        check_val("rst_sa otx_data", {24'b0, otx_data}, 0);
        check_val("rst_sa o_busy", {31'b0, o_busy}, 0);
        check_val("rst_sa o_state", {29'b0, o_state}, 0);
        check_val("rst_sa o_ready", {31'b0, o_ready}, 0);
        check_val("rst_sa o_error", {31'b0, o_error}, 0);
        clear_mon();
        repeat (3) @(negedge iclk);
        check_val("rst_sa quiet", en_n, 0);
        irst = 1'b0;
        run_frame(60, 1, -1, 0, 8'h66, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_transmitter.md
FRAME_TRANSMITTER -- requirements
Module: frame_transmitter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12, giving the idle cycles forced after each frame.
REQ-002 SHALL have parameter MIN_PAYLOAD, default 46, giving the minimum DATA bytes; shorter payloads are zero-padded.
REQ-003 SHALL have parameter MAX_PAYLOAD, default 1500, giving the maximum DATA bytes accepted.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port irst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port istart, input, 1 bit: a one-cycle frame request, accepted only while o_busy=0.
REQ-007 SHALL have ports ida, input, 48 bits, and isa, input, 48 bits: destination and source addresses, latched on istart, MSB byte sent first.
REQ-008 SHALL have port ilen, input, 16 bits: the length field, latched on istart, MSB byte sent first.
REQ-009 SHALL have ports idata, input, 8 bits; ivalid, input, 1 bit; and ilast, input, 1 bit: the payload stream.
REQ-010 SHALL have port o_ready, output, 1 bit: payload byte accepted when ivalid and o_ready are both 1.
REQ-011 SHALL have ports otx_data, output, 8 bits; otx_en, output, 1 bit; and otx_er, output, 1 bit: GMII-style transmit.
REQ-012 SHALL have ports o_state, output, 3 bits (receiver state code), and o_busy, output, 1 bit (high from istart acceptance through end of IFG).
REQ-013 SHALL have port o_error, output, 1 bit: a one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL use states NO_FRAME=000, PREAMBLE=001, DELIMETER=010, DA=011, SA=100, LENGTH=101, DATA=110, FCS=111, plus internal IFG, which reports o_state=000.
REQ-015 SHALL, on accepting istart in cycle T, drive otx_en=1 with otx_data=0x55 from cycle T+1.
REQ-016 SHALL send sequence PREAMBLE 7x0x55, DELIMETER 1x0xD5, DA 6 bytes, SA 6 bytes, LENGTH 2 bytes, DATA, FCS 4 bytes, then IFG for IFG_CYCLES cycles with otx_en=0, then return to NO_FRAME.
REQ-017 SHALL assert o_ready only in DATA while real payload is still expected; otx_data in DATA equals the idata byte accepted in the previous cycle (one-cycle registered path).
REQ-018 SHALL enter FCS after the byte flagged ilast if at least MIN_PAYLOAD bytes have been sent; otherwise it SHALL deassert o_ready and send 0x00 pad bytes up to MIN_PAYLOAD.
REQ-019 SHALL, if ivalid=0 while o_ready=1 (underrun), drive otx_er=1 and otx_en=1 for one cycle, pulse o_error, and go to IFG.
REQ-020 SHALL, if MAX_PAYLOAD bytes are accepted without ilast, abort the same way as REQ-019 in the next cycle.
REQ-021 SHALL compute CRC-32 (reflected 0x04C11DB7) with the shared eth_crc32_8d function: preset to 0xFFFFFFFF in DELIMETER, updated on every DA..pad byte, and not updated during FCS.
REQ-022 SHALL send FCS as the bitwise complement of the CRC, bits [7:0] first, then [15:8], [23:16], [31:24].
REQ-023 SHALL ignore istart while o_busy=1, including during IFG; latched ida/isa/ilen SHALL not change mid-frame.
REQ-024 SHALL hold otx_er=0 except in the abort cycle and hold otx_data=0x00 whenever otx_en=0.

Reset
REQ-025 SHALL, on irst=1, immediately force the state to NO_FRAME and set otx_en=0, otx_er=0, otx_data=0x00, o_ready=0, o_busy=0, o_error=0, o_state=000, all counters to 0, and the CRC to 0xFFFFFFFF.
REQ-026 SHALL, after reset is asserted mid-frame, send no further frame bytes and accept istart on the first clock edge after irst falls.

Structure
REQ-027 SHALL take the state codes, the 0x55/0xD5 constants, and eth_crc32_8d from a shared package (eth_frame_pkg) that the receiver also uses.
REQ-028 SHALL contain one sub-module, tx_crc32_acc (preset, enable, 8-bit data in, 32-bit CRC out); all sequencing SHALL stay in frame_transmitter.

Verification
REQ-029 SHALL cover this case: a 46-byte payload gives 72 otx_en cycles, and looping back into the frame receiver gives CRC residue 0xC704DD7B with crc_correct=1.
REQ-030 SHALL cover this case: a 1-byte payload 0xAB gives 45 bytes of 0x00 pad, 72 otx_en cycles, and o_ready high for exactly 1 cycle.
REQ-031 SHALL cover this case: a 1500-byte payload gives 1526 otx_en cycles; a 1501st byte without ilast causes an abort with otx_er=1 and o_error=1.
REQ-032 SHALL cover this case: dropping ivalid at payload byte 10 gives one otx_er=1 cycle, then otx_en=0 for 12 cycles, with o_busy falling after the IFG.
REQ-033 SHALL cover this case: istart pulsed during IFG is ignored, while istart on the first cycle with o_busy=0 gives 0x55 on the next cycle.
REQ-034 SHALL cover this case: irst asserted in the SA state gives otx_en=0 in the same cycle, all outputs at reset values, and a clean frame on the next istart.
